reg_file_sb: RTL

Parametrised multi-read, dual-write register file with per-register scoreboard (busy) bits for the pipelined CPU datapath. It replaces the single-write register file in the decode stage. Write-back forwarding covers both write ports, and the scoreboard tracks in-flight producers so hazard logic can stall on busy sources. Register 0 is hardwired to zero and is never busy.

---
 rtl/reg_file_sb.sv | 101 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read, dual-write register file with a per-register
// scoreboard (busy) bit. Reads are combinational and forward same-cycle
// write data (port 1 over port 0). Register 0 reads as zero and is never busy.
module reg_file_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [DATA_WIDTH-1:0]          wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd1,
    input  logic                           iss_valid,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;

    // Storage: port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (we0 && (wa0 != '0)) begin
                regs[wa0] <= wd0;
            end
            if (we1 && (wa1 != '0)) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Scoreboard next state: writes retire, issue re-arms, flush clears all.
    always_comb begin
        busy_nxt = busy;
        if (we0 && (wa0 != '0)) begin
            busy_nxt[wa0] = 1'b0;
        end
        if (we1 && (wa1 != '0)) begin
            busy_nxt[wa1] = 1'b0;
        end
        if (iss_valid && (iss_addr != '0)) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: forward write data, mask busy when the producer writes now.
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  hit0;
        logic                  hit1;

        assign a    = ra[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit0 = we0 && (wa0 == a);
        assign hit1 = we1 && (wa1 == a);

        assign rd[i*DATA_WIDTH +: DATA_WIDTH] =
            (rst || (a == '0)) ? '0  :
            hit1               ? wd1 :
            hit0               ? wd0 : regs[a];

        assign rbusy[i] = ~rst & busy[a] & ~hit0 & ~hit1;
    end

    // Population count of the busy vector.
    always_comb begin
        busy_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_cnt = busy_cnt + {{ADDR_WIDTH{1'b0}}, busy[k]};
        end
    end

endmodule
